// File: rtl/xbus_arbiter_pkg.sv
// xbus_arbiter_pkg
//   Shared definitions for the two-master xbus arbiter: bus field widths,
//   timeout counter width and the arbiter state encoding. The encodings
//   are shared with the core's xbus interface, so they must not change.
package xbus_arbiter_pkg;

  localparam int XBUS_ADDR_W = 32;
  localparam int XBUS_DATA_W = 32;
  localparam int XBUS_BE_W   = 4;
  localparam int ARB_CNT_W   = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/xbus_arbiter_if.sv
// xbus_arbiter_if
//   Bundles every bus signal around the arbiter: both master request
//   ports and the shared slave port.
//   modport slave  : the arbiter's view (it serves the two masters and
//                    drives the downstream slave port).
//   modport master : the environment's view (masters and downstream slave).
//
// Handshake: mX_as rises with all fields valid and holds them stable until
// the cycle where mX_ack=1; that ack is a single-cycle completion and mX_err
// qualifies it as a timeout. On the slave side s_ack is only meaningful
// while s_as=1, and mX_rdata is only non-zero while mX_ack=1.
interface xbus_arbiter_if;
  import xbus_arbiter_pkg::*;

  logic                   m0_as,    m1_as;
  logic                   m0_we,    m1_we;
  logic [XBUS_BE_W-1:0]   m0_be,    m1_be;
  logic [XBUS_ADDR_W-1:0] m0_addr,  m1_addr;
  logic [XBUS_DATA_W-1:0] m0_wdata, m1_wdata;
  logic [XBUS_DATA_W-1:0] m0_rdata, m1_rdata;
  logic                   m0_ack,   m1_ack;
  logic                   m0_err,   m1_err;

  logic                   s_as;
  logic                   s_we;
  logic [XBUS_BE_W-1:0]   s_be;
  logic [XBUS_ADDR_W-1:0] s_addr;
  logic [XBUS_DATA_W-1:0] s_wdata;
  logic [XBUS_DATA_W-1:0] s_rdata;
  logic                   s_ack;

  modport slave (
    input  m0_as, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_as, m1_we, m1_be, m1_addr, m1_wdata,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output s_as, s_we, s_be, s_addr, s_wdata,
    input  s_rdata, s_ack
  );

  modport master (
    output m0_as, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_as, m1_we, m1_be, m1_addr, m1_wdata,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  s_as, s_we, s_be, s_addr, s_wdata,
    output s_rdata, s_ack
  );

endinterface

// File: rtl/xbus_arbiter_timer.sv
// xbus_arbiter_timer (arbitration timeout timer)
//   8-bit up counter with synchronous clear (priority) and enable.
//   Ports: clk, rst_n (async active-low), clr, en, hit (cnt == TIMEOUT-1).
module xbus_arbiter_timer
  import xbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [ARB_CNT_W-1:0] HIT_VAL = ARB_CNT_W'(TIMEOUT - 1);

  logic [ARB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter
//   Round-robin arbiter sharing one xbus slave port between master 0
//   (RV32I core) and master 1 (DMA / debug). Ownership is held until the
//   slave acks, the master aborts, or TIMEOUT cycles pass without an ack,
//   in which case the transfer is completed with ack+err.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus         : xbus_arbiter_if.slave (both masters + slave port)
//     dbg_state   : current arbiter state, for observation only
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xbus_arbiter_if.slave        bus,
  output arb_state_t           dbg_state
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       cnt_clr, cnt_en, hit;
  logic       owner, req_as, ack_ok, ack_to, abort;

  xbus_arbiter_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .hit   (hit)
  );

  // last resets to 1 so that the first simultaneous request goes to m0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    ack_ok       = 1'b0;
    ack_to       = 1'b0;
    abort        = 1'b0;
    owner        = (state_q == ARB_GNT1);
    req_as       = owner ? bus.m1_as : bus.m0_as;
    bus.s_as     = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_be     = '0;
    bus.s_addr   = '0;
    bus.s_wdata  = '0;

    case (state_q)
      ARB_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.m0_as && bus.m1_as) begin
          state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        end else if (bus.m0_as) begin
          state_d = ARB_GNT0;
        end else if (bus.m1_as) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        // Slave port is a straight combinational copy of the owner.
        bus.s_as    = req_as;
        bus.s_we    = owner ? bus.m1_we    : bus.m0_we;
        bus.s_be    = owner ? bus.m1_be    : bus.m0_be;
        bus.s_addr  = owner ? bus.m1_addr  : bus.m0_addr;
        bus.s_wdata = owner ? bus.m1_wdata : bus.m0_wdata;
        // A dropped strobe outranks s_ack (which is ignored without s_as);
        // a real ack outranks a timeout landing in the same cycle.
        if (!req_as) begin
          abort = 1'b1;
        end else if (bus.s_ack) begin
          ack_ok = 1'b1;
        end else if (hit) begin
          ack_to = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        if (abort || ack_ok || ack_to) begin
          state_d = ARB_IDLE;
          last_d  = owner;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    bus.m0_ack   = (ack_ok || ack_to) && !owner;
    bus.m1_ack   = (ack_ok || ack_to) &&  owner;
    bus.m0_err   = ack_to && !owner;
    bus.m1_err   = ack_to &&  owner;
    bus.m0_rdata = (ack_ok && !owner) ? bus.s_rdata : '0;
    bus.m1_rdata = (ack_ok &&  owner) ? bus.s_rdata : '0;
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
module tb_xbus_arbiter;
  import xbus_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  int         checks;
  int         errors;

  xbus_arbiter_if bus();

  xbus_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    bus.m0_as = 1'b0; bus.m0_we = 1'b0; bus.m0_be = 4'h0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_as = 1'b0; bus.m1_we = 1'b0; bus.m1_be = 4'h0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.s_ack = 1'b0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_masters();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_masters();
    tick();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARB_IDLE); end
    checks++; if ({bus.s_as, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {bus.s_as, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}); end
    tick();
    rst_n = 1'b1;
    bus.m0_as = 1'b1; bus.m0_we = 1'b1; bus.m0_be = 4'hF; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hA5A5A5A5;
    tick();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_GNT0 || bus.s_as !== 1'b1 || bus.s_addr !== 32'h10) begin errors++; $display("FAIL reset_pre_gnt0: got state=%0d s_as=%b s_addr=%h expected 1 1 00000010", dbg_state, bus.s_as, bus.s_addr); end
    // Asynchronous reset mid-transfer: outputs drop with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.s_as !== 1'b0 || bus.s_addr !== 32'h0 || bus.s_wdata !== 32'h0 || bus.s_we !== 1'b0) begin errors++; $display("FAIL reset_async_slave: got s_as=%b s_addr=%h s_wdata=%h expected all 0", bus.s_as, bus.s_addr, bus.s_wdata); end
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL reset_async_state: got %0d expected %0d", dbg_state, ARB_IDLE); end
    clear_masters();
    tick();
    tick();
    rst_n = 1'b1;
    bus.m0_as = 1'b1; bus.m0_addr = 32'h100;
    bus.m1_as = 1'b1; bus.m1_addr = 32'h200;
    @(negedge clk);
    checks++; if (bus.s_as !== 1'b0) begin errors++; $display("FAIL reset_grant_latency: got s_as=%b expected 0", bus.s_as); end
    tick();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_GNT0 || bus.s_addr !== 32'h100) begin errors++; $display("FAIL reset_first_winner: got state=%0d s_addr=%h expected 1 00000100", dbg_state, bus.s_addr); end
    clear_masters();
  endtask

  task automatic test_single_read();
    int acks;
    acks = 0;
    do_reset();
    bus.m1_as = 1'b1; bus.m1_we = 1'b0; bus.m1_be = 4'hF; bus.m1_addr = 32'h1000;
    bus.s_rdata = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin bus.s_ack = 1'b1; bus.s_rdata = 32'hCAFEF00D; end
      @(negedge clk);
      if (bus.m1_ack === 1'b1) acks++;
      checks++; if (bus.s_as !== 1'b1 || bus.s_addr !== 32'h1000 || bus.s_we !== 1'b0) begin errors++; $display("FAIL read_slave_fields c%0d: got s_as=%b s_addr=%h s_we=%b expected 1 00001000 0", k, bus.s_as, bus.s_addr, bus.s_we); end
      checks++; if (bus.m1_ack !== (k == 3) || bus.m1_err !== 1'b0) begin errors++; $display("FAIL read_m1_ack c%0d: got ack=%b err=%b expected %b 0", k, bus.m1_ack, bus.m1_err, (k == 3)); end
      checks++; if (bus.m1_rdata !== ((k == 3) ? 32'hCAFEF00D : 32'h0)) begin errors++; $display("FAIL read_m1_rdata c%0d: got %h expected %h", k, bus.m1_rdata, ((k == 3) ? 32'hCAFEF00D : 32'h0)); end
      checks++; if (bus.m0_ack !== 1'b0 || bus.m0_err !== 1'b0 || bus.m0_rdata !== 32'h0) begin errors++; $display("FAIL read_m0_quiet c%0d: got ack=%b err=%b rdata=%h expected 0 0 0", k, bus.m0_ack, bus.m0_err, bus.m0_rdata); end
    end
    tick();
    clear_masters();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_IDLE || bus.m1_ack !== 1'b0) begin errors++; $display("FAIL read_back_idle: got state=%0d ack=%b expected 0 0", dbg_state, bus.m1_ack); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL read_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_q[$];
    logic [1:0] exp;
    int acks;
    acks = 0;
    // {m1_ack, m0_ack} per cycle: IDLE, GNT0, IDLE, GNT1, ...
    exp_q = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    bus.m0_as = 1'b1; bus.m0_addr = 32'hA0;
    bus.m1_as = 1'b1; bus.m1_addr = 32'hB0;
    bus.s_ack = 1'b1; bus.s_rdata = 32'h11112222;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      exp = exp_q.pop_front();
      if (bus.m0_ack === 1'b1) acks++;
      if (bus.m1_ack === 1'b1) acks++;
      checks++; if ({bus.m1_ack, bus.m0_ack} !== exp || bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0) begin errors++; $display("FAIL contention_acks c%0d: got {m1,m0}=%b%b err=%b%b expected %b 00", c, bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err, exp); end
      if (exp == 2'b10) begin
        checks++; if (bus.s_addr !== 32'hB0 || bus.m1_rdata !== 32'h11112222) begin errors++; $display("FAIL contention_m1_path c%0d: got s_addr=%h rdata=%h expected 000000b0 11112222", c, bus.s_addr, bus.m1_rdata); end
      end
    end
    checks++; if (acks !== 4) begin errors++; $display("FAIL contention_count: got %0d expected 4", acks); end
    clear_masters();
  endtask

  task automatic test_timeout(input logic ack_at_end);
    logic [31:0] exp_rdata;
    do_reset();
    bus.m0_as = 1'b1; bus.m0_we = 1'b1; bus.m0_be = 4'h3; bus.m0_addr = 32'h2000; bus.m0_wdata = 32'h12345678;
    bus.s_rdata = 32'h55AA55AA;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4 && ack_at_end) begin bus.s_ack = 1'b1; bus.s_rdata = 32'h0BADCAFE; end
      @(negedge clk);
      exp_rdata = (k == 4 && ack_at_end) ? 32'h0BADCAFE : 32'h0;
      checks++; if (dbg_state !== ARB_GNT0 || bus.s_wdata !== 32'h12345678 || bus.s_be !== 4'h3 || bus.s_we !== 1'b1) begin errors++; $display("FAIL timeout_fields ack=%b c%0d: got state=%0d wdata=%h be=%h we=%b expected 1 12345678 3 1", ack_at_end, k, dbg_state, bus.s_wdata, bus.s_be, bus.s_we); end
      checks++; if (bus.m0_ack !== (k == 4) || bus.m0_err !== (k == 4 && !ack_at_end)) begin errors++; $display("FAIL timeout_ack_err ack=%b c%0d: got ack=%b err=%b expected %b %b", ack_at_end, k, bus.m0_ack, bus.m0_err, (k == 4), (k == 4 && !ack_at_end)); end
      checks++; if (bus.m0_rdata !== exp_rdata) begin errors++; $display("FAIL timeout_rdata ack=%b c%0d: got %h expected %h", ack_at_end, k, bus.m0_rdata, exp_rdata); end
    end
    tick();
    clear_masters();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_IDLE || bus.m0_ack !== 1'b0 || bus.m0_err !== 1'b0) begin errors++; $display("FAIL timeout_back_idle ack=%b: got state=%0d ack=%b err=%b expected 0 0 0", ack_at_end, dbg_state, bus.m0_ack, bus.m0_err); end
  endtask

  task automatic test_abort();
    do_reset();
    bus.m1_as = 1'b1; bus.m1_addr = 32'h3000;
    tick();
    bus.m0_as = 1'b1; bus.m0_addr = 32'h4000;
    @(negedge clk);
    checks++; if (dbg_state !== ARB_GNT1 || bus.s_as !== 1'b1 || bus.s_addr !== 32'h3000) begin errors++; $display("FAIL abort_gnt1: got state=%0d s_as=%b s_addr=%h expected 2 1 00003000", dbg_state, bus.s_as, bus.s_addr); end
    tick();
    bus.m1_as = 1'b0;
    bus.s_ack = 1'b1; bus.s_rdata = 32'h77777777;
    @(negedge clk);
    checks++; if (bus.s_as !== 1'b0) begin errors++; $display("FAIL abort_s_as: got %b expected 0", bus.s_as); end
    checks++; if (bus.m1_ack !== 1'b0 || bus.m0_ack !== 1'b0 || bus.m1_rdata !== 32'h0) begin errors++; $display("FAIL abort_no_ack: got m1_ack=%b m0_ack=%b m1_rdata=%h expected 0 0 0", bus.m1_ack, bus.m0_ack, bus.m1_rdata); end
    tick();
    bus.s_ack = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL abort_idle: got %0d expected %0d", dbg_state, ARB_IDLE); end
    tick();
    @(negedge clk);
    checks++; if (dbg_state !== ARB_GNT0 || bus.s_addr !== 32'h4000) begin errors++; $display("FAIL abort_next_m0: got state=%0d s_addr=%h expected 1 00004000", dbg_state, bus.s_addr); end
    clear_masters();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_masters();
    test_reset();
    test_single_read();
    test_contention();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
# xbus_arbiter

Two-master arbiter that shares a single xbus slave port between the RV32I core (master 0) and a second bus master such as a DMA or debug unit (master 1). It adds a wait-capable handshake: the slave may take several cycles to acknowledge. The arbiter uses round-robin fairness, holds ownership until the slave acknowledges, and terminates hung transfers with an error after a programmable timeout. It sits between the masters' xbus outputs and the memory/peripheral decoder.

## Interface

Parameters:
- TIMEOUT, 15: cycles a granted transfer may wait for s_ack before forced error termination; legal range 1..255.

Ports:
- clk  in  1  Single system clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- m0_as, m1_as  in  1  Master request (address strobe). Must stay high, with all fields stable, until that master's ack.
- m0_we, m1_we  in  1  Write enable.
- m0_be, m1_be  in  4  Byte enables.
- m0_addr, m1_addr  in  32  Address.
- m0_wdata, m1_wdata  in  32  Write data.
- m0_rdata, m1_rdata  out  32  Read data. Valid only while the matching ack is high; 0 otherwise.
- m0_ack, m1_ack  out  1  One-cycle transfer completion.
- m0_err, m1_err  out  1  High together with ack when the transfer timed out.
- s_as, s_we  out  1  Slave-side strobe and write enable.
- s_be  out  4  Slave byte enables.
- s_addr, s_wdata  out  32  Slave address and write data.
- s_rdata  in  32  Slave read data.
- s_ack  in  1  Slave completion. Sampled only while s_as=1.

## Operation

- State machine has three states: IDLE, GNT0, GNT1. An internal `last` bit records the most recent owner. A timeout counter `cnt` is 8 bits wide.
- In IDLE:
  - Only m0_as high: next state is GNT0.
  - Only m1_as high: next state is GNT1.
  - Both high: the master other than `last` wins.
  - Neither high: stay in IDLE.
  - All slave outputs are 0. All master acks, errs and rdata are 0.
- In GNTx:
  - s_as, s_we, s_be, s_addr and s_wdata are a combinational copy of master x's fields.
  - The other master sees ack=0, err=0 and rdata=0.
- Completion in GNTx (s_ack=1):
  - mx_ack=1 and mx_rdata=s_rdata in the same cycle.
  - Next state is IDLE; `last` is set to x; `cnt` is cleared.
- Timeout in GNTx:
  - While s_ack=0, `cnt` increments every cycle.
  - In the cycle where cnt==TIMEOUT-1 and s_ack=0, assert mx_ack=1 and mx_err=1 with mx_rdata=0.
  - Next state is IDLE; `last` is set to x; `cnt` is cleared.
  - If s_ack=1 in that same cycle, it takes precedence: normal completion, no err.
- Abort: if mx_as drops while in GNTx (a protocol violation), then:
  - s_as goes to 0 that cycle and no ack is issued.
  - Next state is IDLE; `last` is set to x; `cnt` is cleared.
- Reset (asynchronous, may occur mid-transfer): state=IDLE, last=1, cnt=0. All outputs go to 0 immediately, without waiting for a clock edge. An in-flight transfer is dropped silently.

## Timing

- Grant latency is one cycle: a request seen in IDLE at edge N is presented on the slave port in cycle N+1.
- Minimum transfer is 2 cycles: 1 cycle in IDLE, then 1 cycle in GNT with s_ack already high.
- Every transfer is followed by at least one IDLE cycle, so the peak rate is 1 transfer per 2 cycles. A master that keeps requesting waits at most one foreign transfer before it is granted.
- Maximum transfer length is 1 + TIMEOUT cycles.
- The s_rdata to mx_rdata path and the s_ack to mx_ack path are combinational.

## Structure

- Shared header `src/core/xbus_defs.v` holds:
  - state encodings ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2;
  - the xbus field widths.
  
  The core's xbus interface uses the same header.
- Sub-module `arb_timer`: an 8-bit counter with clear, enable and a `hit` output (cnt==TIMEOUT-1). It is instantiated once.
- The arbiter also uses the existing `register` module for the state and `last` flops, adapted for async active-low reset.

## Test plan

- Reset: assert rst_n=0 mid-GNT0 → all outputs drop to 0 without a clock edge. After release, simultaneous requests grant m0 first.
- Single read: m1 reads addr 0x1000; slave acks after 3 cycles with 0xCAFEF00D → m1_ack pulses once with m1_rdata=0xCAFEF00D. m0 outputs stay 0 throughout.
- Contention: m0 and m1 both request continuously, slave acks immediately → grants alternate m0, m1, m0, m1 with one IDLE cycle between each, 4 acks in 8 cycles.
- Timeout: TIMEOUT=4, m0 writes 0x2000 and s_ack stays 0 → m0_ack=m0_err=1 in the 4th GNT0 cycle with m0_rdata=0, then IDLE.
- Ack at timeout boundary: s_ack=1 exactly in the 4th GNT0 cycle → ack with err=0 and rdata passed through.
- Abort: m1 drops m1_as mid-grant → s_as=0 that cycle, no m1_ack, next grant goes to a pending m0.
